// File: rtl/int_controller.sv
// Prioritized interrupt controller: latches source events into PENDING, applies
// per-source mask and edge/level mode, and runs an irq/ack/done handshake with the core.
module int_controller #(
    parameter int INT_SIG_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [INT_SIG_WIDTH-1:0] int_sig,
    input  logic                     cfg_we,
    input  logic                     cfg_re,
    input  logic [1:0]               cfg_addr,
    input  logic [31:0]              cfg_wdata,
    output logic [31:0]              cfg_rdata,
    output logic                     irq,
    output logic [2:0]               irq_id,
    input  logic                     irq_ack,
    input  logic                     irq_done
);

    localparam int W = INT_SIG_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   mask;
    logic [W-1:0]   mode;
    logic [W-1:0]   pending;
    logic [W-1:0]   prev_sig;

    logic [W-1:0]   set_vec;
    logic [W-1:0]   w1c_vec;
    logic [W-1:0]   ack_vec;
    logic [W-1:0]   pending_next;
    logic [W-1:0]   mask_next;
    logic [W-1:0]   eligible;
    logic [2:0]     hi_idx;
    logic           ack_take;
    logic           withdraw;

    // Sets take priority over both clear paths; edge sources need a 0->1 transition,
    // level sources set every cycle they are high.
    always_comb begin
        set_vec      = int_sig & (~prev_sig | ~mode);
        w1c_vec      = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[W-1:0] : '0;
        ack_take     = (state == REQ) && irq_ack;
        ack_vec      = ack_take ? (W'(1) << irq_id) : '0;
        pending_next = (pending & ~(w1c_vec | ack_vec)) | set_vec;
        mask_next    = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[W-1:0] : mask;
        eligible     = pending & mask;
        withdraw     = !mask_next[irq_id] || !pending_next[irq_id];
        hi_idx       = 3'd0;
        for (int i = 0; i < W; i++) begin
            if (eligible[i]) begin
                hi_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mask     <= '0;
            mode     <= '1;
            pending  <= '0;
            prev_sig <= '0;
        end else begin
            prev_sig <= int_sig;
            pending  <= pending_next;
            mask     <= mask_next;
            if (cfg_we && cfg_addr == 2'd1) begin
                mode <= cfg_wdata[W-1:0];
            end
        end
    end

    // Request FSM; irq_id is latched on entry to REQ and held until the next request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            irq    <= 1'b0;
            irq_id <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        state  <= REQ;
                        irq    <= 1'b1;
                        irq_id <= hi_idx;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        state <= SERVICE;
                        irq   <= 1'b0;
                    end else if (withdraw) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_rdata <= 32'd0;
        end else if (cfg_re) begin
            case (cfg_addr)
                2'd0:    cfg_rdata <= 32'(mask);
                2'd1:    cfg_rdata <= 32'(mode);
                2'd2:    cfg_rdata <= 32'(pending);
                default: cfg_rdata <= {26'd0, irq, irq_id, state};
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller; inputs change and outputs are
// observed on the falling clock edge.
module tb_int_controller;

    logic        clk;
    logic        nrst;
    logic [5:0]  int_sig;
    logic        cfg_we;
    logic        cfg_re;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq;
    logic [2:0]  irq_id;
    logic        irq_ack;
    logic        irq_done;

    int passed;
    int total;

    int_controller #(.INT_SIG_WIDTH(6)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .int_sig   (int_sig),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq       (irq),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 32'd0;
    endtask

    task automatic cfg_read(input logic [1:0] addr, output logic [31:0] data);
        cfg_re   = 1'b1;
        cfg_addr = addr;
        tick();
        cfg_re   = 1'b0;
        data     = cfg_rdata;
    endtask

    task automatic pulse(input logic [5:0] bits);
        int_sig = bits;
        tick();
        int_sig = 6'd0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_done();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        nrst = 1'b0;
        tick();
        total++;
        if (irq !== 1'b0 || irq_id !== 3'd0 || cfg_rdata !== 32'd0) begin
            $display("[TB] FAIL reset_outputs irq=%b id=%0d rdata=%h want 0/0/0", irq, irq_id, cfg_rdata);
        end else passed++;
        nrst = 1'b1;
        tick();
        cfg_read(2'd1, rd);
        total++;
        if (rd !== 32'h3F) $display("[TB] FAIL reset_mode got %h want 0000003f", rd);
        else passed++;
        cfg_read(2'd0, rd);
        total++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_mask got %h want 0", rd);
        else passed++;
        cfg_read(2'd3, rd);
        total++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_status got %h want 0", rd);
        else passed++;
    endtask

    task automatic test_single();
        logic [31:0] rd;
        cfg_write(2'd0, 32'h3F);
        pulse(6'h08);
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL single_n1_irq got %b want 0", irq);
        else passed++;
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd3) $display("[TB] FAIL single_n2 irq=%b id=%0d want 1/3", irq, irq_id);
        else passed++;
        cfg_read(2'd3, rd);
        total++;
        if (rd !== 32'd45) $display("[TB] FAIL single_status_req got %0d want 45", rd);
        else passed++;
        do_ack();
        total++;
        if (irq !== 1'b0 || irq_id !== 3'd3) $display("[TB] FAIL single_ack irq=%b id=%0d want 0/3", irq, irq_id);
        else passed++;
        cfg_read(2'd2, rd);
        total++;
        if (rd !== 32'h0) $display("[TB] FAIL single_pending got %h want 0", rd);
        else passed++;
        cfg_read(2'd3, rd);
        total++;
        if (rd !== 32'd14) $display("[TB] FAIL single_status_svc got %0d want 14", rd);
        else passed++;
        do_done();
        cfg_read(2'd3, rd);
        total++;
        if (rd !== 32'd12) $display("[TB] FAIL single_status_idle got %0d want 12", rd);
        else passed++;
    endtask

    task automatic test_priority();
        pulse(6'h22);
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd5) $display("[TB] FAIL prio_first irq=%b id=%0d want 1/5", irq, irq_id);
        else passed++;
        do_ack();
        do_done();
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL prio_gap irq=%b want 0", irq);
        else passed++;
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd1) $display("[TB] FAIL prio_second irq=%b id=%0d want 1/1", irq, irq_id);
        else passed++;
        do_ack();
        do_done();
    endtask

    task automatic test_level();
        cfg_write(2'd1, 32'h3E);
        int_sig = 6'h01;
        tick();
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd0) $display("[TB] FAIL level_first irq=%b id=%0d want 1/0", irq, irq_id);
        else passed++;
        do_ack();
        do_done();
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd0) $display("[TB] FAIL level_reissue irq=%b id=%0d want 1/0", irq, irq_id);
        else passed++;
        irq_ack = 1'b1;
        int_sig = 6'h00;
        tick();
        irq_ack = 1'b0;
        do_done();
        tick();
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL level_released irq=%b want 0", irq);
        else passed++;
        cfg_write(2'd1, 32'h3F);
        int_sig = 6'h01;
        tick();
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd0) $display("[TB] FAIL edge_held_first irq=%b id=%0d want 1/0", irq, irq_id);
        else passed++;
        do_ack();
        do_done();
        tick();
        tick();
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL edge_held_once irq=%b want 0", irq);
        else passed++;
        int_sig = 6'h00;
        tick();
    endtask

    task automatic test_mask();
        logic [31:0] rd;
        cfg_write(2'd0, 32'h0);
        pulse(6'h04);
        tick();
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL mask_blocked irq=%b want 0", irq);
        else passed++;
        cfg_read(2'd2, rd);
        total++;
        if (rd !== 32'h04) $display("[TB] FAIL mask_pending got %h want 4", rd);
        else passed++;
        cfg_write(2'd0, 32'h04);
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL mask_enable_early irq=%b want 0", irq);
        else passed++;
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd2) $display("[TB] FAIL mask_enable irq=%b id=%0d want 1/2", irq, irq_id);
        else passed++;
        cfg_write(2'd0, 32'h0);
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL mask_withdraw irq=%b want 0", irq);
        else passed++;
        cfg_read(2'd3, rd);
        total++;
        if (rd !== 32'd8) $display("[TB] FAIL mask_withdraw_status got %0d want 8", rd);
        else passed++;
        cfg_read(2'd2, rd);
        total++;
        if (rd !== 32'h04) $display("[TB] FAIL mask_withdraw_pending got %h want 4", rd);
        else passed++;
    endtask

    task automatic test_w1c();
        logic [31:0] rd;
        int_sig   = 6'h04;
        cfg_we    = 1'b1;
        cfg_addr  = 2'd2;
        cfg_wdata = 32'h04;
        tick();
        int_sig   = 6'h00;
        cfg_we    = 1'b0;
        cfg_wdata = 32'd0;
        cfg_read(2'd2, rd);
        total++;
        if (rd !== 32'h04) $display("[TB] FAIL w1c_set_wins got %h want 4", rd);
        else passed++;
        cfg_write(2'd2, 32'h04);
        cfg_read(2'd2, rd);
        total++;
        if (rd !== 32'h0) $display("[TB] FAIL w1c_clear got %h want 0", rd);
        else passed++;
        cfg_write(2'd3, 32'hFFFF_FFFF);
        cfg_read(2'd3, rd);
        total++;
        if (rd !== 32'd8) $display("[TB] FAIL status_write_ignored got %0d want 8", rd);
        else passed++;
        cfg_we    = 1'b1;
        cfg_re    = 1'b1;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'h3F;
        tick();
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        total++;
        if (cfg_rdata !== 32'h0) $display("[TB] FAIL rw_same_cycle got %h want 0", cfg_rdata);
        else passed++;
        cfg_read(2'd0, rd);
        total++;
        if (rd !== 32'h3F) $display("[TB] FAIL rw_new_mask got %h want 3f", rd);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        pulse(6'h10);
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 3'd4) $display("[TB] FAIL pre_reset_req irq=%b id=%0d want 1/4", irq, irq_id);
        else passed++;
        #2 nrst = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0 || irq_id !== 3'd0) $display("[TB] FAIL async_irq_drop irq=%b id=%0d want 0/0", irq, irq_id);
        else passed++;
        tick();
        nrst = 1'b1;
        tick();
        cfg_write(2'd0, 32'h3F);
        pulse(6'h10);
        tick();
        do_ack();
        pulse(6'h02);
        tick();
        #2 nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        total++;
        if (irq !== 1'b0) $display("[TB] FAIL svc_reset_irq got %b want 0", irq);
        else passed++;
        cfg_read(2'd3, rd);
        total++;
        if (rd !== 32'h0) $display("[TB] FAIL svc_reset_status got %h want 0", rd);
        else passed++;
        cfg_read(2'd2, rd);
        total++;
        if (rd !== 32'h0) $display("[TB] FAIL svc_reset_pending got %h want 0", rd);
        else passed++;
        cfg_read(2'd0, rd);
        total++;
        if (rd !== 32'h0) $display("[TB] FAIL svc_reset_mask got %h want 0", rd);
        else passed++;
        cfg_read(2'd1, rd);
        total++;
        if (rd !== 32'h3F) $display("[TB] FAIL svc_reset_mode got %h want 3f", rd);
        else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        passed    = 0;
        total     = 0;
        nrst      = 1'b0;
        int_sig   = 6'd0;
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'd0;
        irq_ack   = 1'b0;
        irq_done  = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_level();
        test_mask();
        test_w1c();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
